// File: rtl/stepper_move_ctrl.sv
// Move sequencer for the 4-phase stepper driver: runs a counted move, watches the
// driver's one-hot phase for progress, stops the motor and flags phase/stall faults.
//
// state  | meaning
// IDLE   | motor stopped, waiting for start
// RUN    | dir commanded, counting step events toward the target
// STOP   | dir=00, waiting for the driver to report phase 0
// FAULT  | motor stopped, fault_code held until fault_clr
module stepper_move_ctrl #(
  parameter int W            = 16,
  parameter int STALL_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         reel_out,
  input  logic [W-1:0] steps,
  input  logic         abort,
  input  logic         fault_clr,
  input  logic [3:0]   phase,
  output logic [1:0]   dir,
  output logic         busy,
  output logic         done,
  output logic         fault,
  output logic [1:0]   fault_code,
  output logic [W-1:0] step_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STOP  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [1:0] C_NONE    = 2'b00;
  localparam logic [1:0] C_ILLEGAL = 2'b01;
  localparam logic [1:0] C_SEQ     = 2'b10;
  localparam logic [1:0] C_STALL   = 2'b11;

  localparam int              WD_W    = $clog2(STALL_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [W-1:0]    CNT_ONE = W'(1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      phase_q;
  logic [W-1:0]    target_q, target_d;
  logic            reel_q, reel_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [W-1:0]    count_d;
  logic [1:0]      code_d;
  logic            done_d;

  logic            phase_chg, phase_ok, step_evt, wd_expire;
  logic [3:0]      exp_phase;

  function automatic logic [3:0] next_phase(input logic [3:0] q, input logic out);
    logic [3:0] r;
    r = 4'd0;
    case (q)
      4'd0:    r = out ? 4'd1 : 4'd8;
      4'd1:    r = out ? 4'd2 : 4'd8;
      4'd2:    r = out ? 4'd4 : 4'd1;
      4'd4:    r = out ? 4'd8 : 4'd2;
      4'd8:    r = out ? 4'd1 : 4'd4;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    phase_chg = (phase != phase_q);
    phase_ok  = (phase == 4'd0) || (phase == 4'd1) || (phase == 4'd2) ||
                (phase == 4'd4) || (phase == 4'd8);
    step_evt  = phase_chg && phase_ok && (phase != 4'd0);
    exp_phase = next_phase(phase_q, reel_q);
    wd_expire = (wd_q == WD_LAST);

    state_d  = state_q;
    target_d = target_q;
    reel_d   = reel_q;
    count_d  = step_count;
    code_d   = fault_code;
    done_d   = 1'b0;
    wd_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          if (steps == '0) begin
            done_d = 1'b1;
          end else begin
            target_d = steps;
            reel_d   = reel_out;
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        wd_d = wd_q + WD_ONE;
        if (phase_chg && (!phase_ok || phase == 4'd0)) begin
          state_d = S_FAULT;
          code_d  = C_ILLEGAL;
        end else if (phase_chg && phase != exp_phase) begin
          state_d = S_FAULT;
          code_d  = C_SEQ;
        end else begin
          if (phase_chg) begin
            wd_d = '0;
            if (step_count < target_q) count_d = step_count + CNT_ONE;
          end
          // a step landing with abort is still counted before stopping
          if (count_d == target_q || abort) begin
            state_d = S_STOP;
            wd_d    = '0;
          end else if (!phase_chg && wd_expire) begin
            state_d = S_FAULT;
            code_d  = C_STALL;
          end
        end
      end
      S_STOP: begin
        wd_d = wd_q + WD_ONE;
        if (!phase_ok) begin
          state_d = S_FAULT;
          code_d  = C_ILLEGAL;
        end else if (phase == 4'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (step_evt) begin
          // overshoot step from driver tick alignment: not counted, but it is progress
          wd_d = '0;
        end else if (wd_expire) begin
          state_d = S_FAULT;
          code_d  = C_STALL;
        end
      end
      default: begin
        if (fault_clr) begin
          state_d = S_IDLE;
          code_d  = C_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 4'd0;
      target_q   <= '0;
      reel_q     <= 1'b0;
      wd_q       <= '0;
      dir        <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= C_NONE;
      step_count <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase;
      target_q   <= target_d;
      reel_q     <= reel_d;
      wd_q       <= wd_d;
      dir        <= (state_d == S_RUN) ? {1'b1, reel_d} : 2'b00;
      busy       <= (state_d == S_RUN) || (state_d == S_STOP);
      done       <= done_d;
      fault      <= (state_d == S_FAULT);
      fault_code <= code_d;
      step_count <= count_d;
    end
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Bench for stepper_move_ctrl: table of move scenarios, randomized moves against an
// outcome model, and hand sequences for reset, stall and start/abort corner cases.
module tb_stepper_move_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         reel_out = 1'b0;
  logic [W-1:0] steps = '0;
  logic         abort = 1'b0;
  logic         fault_clr = 1'b0;
  logic [3:0]   phase = 4'd0;
  logic [1:0]   dir;
  logic         busy;
  logic         done;
  logic         fault;
  logic [1:0]   fault_code;
  logic [W-1:0] step_count;

  int checks = 0;
  int failures = 0;

  stepper_move_ctrl #(.W(W), .STALL_CYCLES(1024)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .reel_out(reel_out),
    .steps(steps), .abort(abort), .fault_clr(fault_clr), .phase(phase),
    .dir(dir), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code), .step_count(step_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    bit         rout;
    int         abort_at;
    int         bad_at;
    int         bad_kind;   // 0 none, 1 illegal code, 2 wrong sequence
    bit         overshoot;
    int         exp_cnt;
    bit         exp_done;
    logic [1:0] exp_code;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Driver rotation written as shifts of the one-hot phase.
  function automatic logic [3:0] nxt(input logic [3:0] p, input logic out);
    if (out) return (p == 4'd0 || p == 4'd8) ? 4'd1 : (p << 1);
    else     return (p == 4'd0 || p == 4'd1) ? 4'd8 : (p >> 1);
  endfunction

  function automatic logic [3:0] pick_bad(input logic [3:0] cur, input logic [3:0] good, input int kind);
    logic [3:0] ill [11];
    logic [3:0] leg [4];
    logic [3:0] r;
    int base;
    ill = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    leg = '{4'd1, 4'd2, 4'd4, 4'd8};
    r = good;
    if (kind == 1) begin
      if (cur != 4'd0 && $urandom_range(0, 3) == 0) r = 4'd0;
      else r = ill[$urandom_range(0, 10)];
    end else begin
      base = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        if (leg[(base + i) % 4] != cur && leg[(base + i) % 4] != good) r = leg[(base + i) % 4];
      end
    end
    return r;
  endfunction

  // Outcome of a whole move from its parameters alone.
  function automatic void model(input int n, input int abort_at, input int bad_at, input int kind,
                                output int cnt, output bit dn, output logic [1:0] code);
    int stop_at;
    stop_at = (abort_at > 0 && abort_at < n) ? abort_at : n;
    if (bad_at > 0 && bad_at <= stop_at) begin
      cnt = bad_at - 1; dn = 1'b0; code = (kind == 1) ? 2'b01 : 2'b10;
    end else begin
      cnt = stop_at; dn = 1'b1; code = 2'b00;
    end
  endfunction

  task automatic run_move(input int n, input bit rout, input int abort_at, input int bad_at,
                          input int kind, input bit overshoot,
                          output int cnt, output bit got_done, output logic [1:0] got_code);
    logic [3:0] p;
    bit ended;
    bit got_fault;
    ended = 1'b0; got_fault = 1'b0; got_done = 1'b0; got_code = 2'b00;
    start = 1'b1; steps = n[W-1:0]; reel_out = rout;
    tick;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_dir", dir, {30'd0, 1'b1, rout});
    for (int k = 1; k <= n && !ended; k++) begin
      repeat ($urandom_range(0, 3)) tick;
      p = nxt(phase, rout);
      if (k == bad_at) p = pick_bad(phase, p, kind);
      phase = p;
      abort = (k == abort_at);
      tick;
      abort = 1'b0;
      if (fault) begin
        got_fault = 1'b1;
        got_code = fault_code;
        chk("fault_dir", dir, 0);
        chk("fault_busy", busy, 0);
        ended = 1'b1;
      end else if (dir == 2'b00) begin
        ended = 1'b1;
      end
    end
    if (!got_fault) begin
      chk("stop_dir", dir, 0);
      chk("stop_busy", busy, 1);
      if (overshoot) begin
        phase = nxt(phase, rout);
        tick;
        chk("overshoot_nofault", fault, 0);
      end
      phase = 4'd0;
      tick;
      got_done = done;
      chk("done_busy", busy, 0);
      cnt = int'(step_count);
      tick;
      chk("done_width", done, 0);
    end else begin
      cnt = int'(step_count);
      phase = 4'd0;
      tick;
      fault_clr = 1'b1;
      tick;
      fault_clr = 1'b0;
      chk("clr_fault", fault, 0);
      chk("clr_code", fault_code, 0);
    end
  endtask

  task automatic wait_stall(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 1100 && !fault; i++) begin
      tick;
      n++;
    end
    chk({name, "_code"}, fault_code, 2'b11);
    chk({name, "_window"}, (n >= 1023 && n <= 1025), 1);
    chk({name, "_dir"}, dir, 0);
    phase = 4'd0;
    tick;
    fault_clr = 1'b1;
    tick;
    fault_clr = 1'b0;
    chk({name, "_clr"}, fault, 0);
  endtask

  initial begin
    int cnt, ecnt;
    bit dn, edn;
    logic [1:0] code, ecode;

    tbl[0] = '{3,  1'b1, 0, 0, 0, 1'b0, 3, 1'b1, 2'b00};
    tbl[1] = '{5,  1'b0, 0, 0, 0, 1'b1, 5, 1'b1, 2'b00};
    tbl[2] = '{10, 1'b1, 2, 0, 0, 1'b0, 2, 1'b1, 2'b00};
    tbl[3] = '{4,  1'b1, 0, 3, 2, 1'b0, 2, 1'b0, 2'b10};
    tbl[4] = '{4,  1'b1, 0, 2, 1, 1'b0, 1, 1'b0, 2'b01};
    tbl[5] = '{1,  1'b0, 0, 0, 0, 1'b1, 1, 1'b1, 2'b00};
    tbl[6] = '{6,  1'b0, 3, 3, 2, 1'b0, 2, 1'b0, 2'b10};

    // reset with phase and start active
    reset_n = 1'b0; phase = 4'd4; start = 1'b1; steps = 16'd3; reel_out = 1'b1;
    tick; tick;
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_count", step_count, 0);
    start = 1'b0; reset_n = 1'b1; phase = 4'd0;
    tick;

    foreach (tbl[i]) begin
      run_move(tbl[i].n, tbl[i].rout, tbl[i].abort_at, tbl[i].bad_at, tbl[i].bad_kind,
               tbl[i].overshoot, cnt, dn, code);
      chk($sformatf("tbl%0d_count", i), cnt, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_done", i), dn, tbl[i].exp_done);
      chk($sformatf("tbl%0d_code", i), code, tbl[i].exp_code);
    end

    // zero-step request
    start = 1'b1; steps = 16'd0; reel_out = 1'b1;
    tick;
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_dir", dir, 0);
    chk("zero_count", step_count, 0);
    tick;
    chk("zero_done_off", done, 0);
    chk("zero_busy2", busy, 0);

    // start together with abort in IDLE: start wins
    start = 1'b1; abort = 1'b1; steps = 16'd1; reel_out = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 1);
    phase = 4'd1; tick;
    phase = 4'd0; tick;
    chk("start_abort_done", done, 1);
    chk("start_abort_count", step_count, 1);

    // start during RUN is ignored
    start = 1'b1; steps = 16'd3; reel_out = 1'b0;
    tick;
    start = 1'b0;
    phase = 4'd8; tick;
    start = 1'b1; steps = 16'd9; tick; start = 1'b0;
    phase = 4'd4; tick;
    phase = 4'd2; tick;
    chk("ign_start_dir", dir, 0);
    chk("ign_start_count", step_count, 3);
    phase = 4'd0; tick;
    chk("ign_start_done", done, 1);

    // stall in RUN
    start = 1'b1; steps = 16'd3; reel_out = 1'b1;
    tick;
    start = 1'b0;
    wait_stall("stall_run");

    // stall in STOP with phase stuck at 8
    start = 1'b1; steps = 16'd4; reel_out = 1'b1;
    tick;
    start = 1'b0;
    phase = 4'd1; tick;
    phase = 4'd2; tick;
    phase = 4'd4; tick;
    phase = 4'd8; tick;
    chk("stall_stop_dir0", dir, 0);
    chk("stall_stop_count", step_count, 4);
    wait_stall("stall_stop");

    // reset in the middle of a move
    start = 1'b1; steps = 16'd10; reel_out = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      phase = nxt(phase, 1'b1);
      tick;
    end
    chk("mid_count7", step_count, 7);
    reset_n = 1'b0;
    tick;
    chk("mid_rst_dir", dir, 0);
    chk("mid_rst_count", step_count, 0);
    chk("mid_rst_busy", busy, 0);
    reset_n = 1'b1; phase = 4'd0;
    tick;
    run_move(2, 1'b0, 0, 0, 0, 1'b0, cnt, dn, code);
    chk("after_rst_count", cnt, 2);
    chk("after_rst_done", dn, 1);

    // randomized moves against the outcome model
    for (int r = 0; r < 25; r++) begin
      int n, ab, bad, kind;
      bit rout, ov;
      n    = $urandom_range(1, 12);
      rout = 1'($urandom_range(0, 1));
      ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
      bad  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
      kind = (bad > 0) ? $urandom_range(1, 2) : 0;
      ov   = 1'($urandom_range(0, 1));
      model(n, ab, bad, kind, ecnt, edn, ecode);
      run_move(n, rout, ab, bad, kind, ov, cnt, dn, code);
      chk($sformatf("rnd%0d_count", r), cnt, ecnt);
      chk($sformatf("rnd%0d_done", r), dn, edn);
      chk($sformatf("rnd%0d_code", r), code, ecode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stepper_move_ctrl.md
# stepper_move_ctrl

Closed-loop move sequencer for the team's 4-phase stepper driver. It accepts a move request (step count plus direction) and drives the driver's 2-bit `dir` command. It monitors the driver's one-hot phase output to count completed steps, then commands a stop and signals completion. It also detects illegal phase codes, wrong-direction steps and stalls, and latches a fault. It sits between the level-finder control logic and the stepper driver.

## Interface
- `W`, 16: width of step request/count.
- `STALL_CYCLES`, 1024: max clocks between steps (and for stop-settle) before a stall fault; driver steps every 512 clocks.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  move request; sampled in IDLE only.
- `reel_out`  in  1  1 = reel out (dir 11), 0 = reel in (dir 10); latched with `start`.
- `steps`  in  W  number of steps to move; latched with `start`.
- `abort`  in  1  terminate current move; ignored in IDLE and FAULT.
- `fault_clr`  in  1  leave FAULT; ignored elsewhere.
- `phase`  in  4  driver phase output: 0, 1, 2, 4, 8 legal.
- `dir`  out  2  driver command: 00 stop, 10 reel in, 11 reel out.
- `busy`  out  1  high in RUN and STOP.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  high in FAULT.
- `fault_code`  out  2  01 illegal phase, 10 wrong sequence, 11 stall; held until `fault_clr`.
- `step_count`  out  W  steps completed in the current or last move.

## Operation
- The block registers `phase` into `phase_q` every cycle in all states.
- A step event is defined as `phase != phase_q`, with `phase` legal and nonzero.
- Expected next phase from `phase_q`:
  - Reel out: 0→1, 1→2, 2→4, 4→8, 8→1.
  - Reel in: 0→8, 1→8, 2→1, 4→2, 8→4.
- States: IDLE, RUN, STOP, FAULT.
- IDLE: `dir`=00. On `start`:
  - `steps`==0: `done` pulses the next cycle, `step_count`←0, and the block stays in IDLE.
  - Otherwise it latches `steps` and `reel_out`, sets `step_count`←0, and enters RUN.
  - `start` and `abort` asserted together in IDLE: `start` acts; `abort` is ignored.
- RUN: `dir`={1,reel_out}. Any `phase` change is checked in this order:
  - Illegal code (not 0/1/2/4/8, or 0) → FAULT with code 01.
  - Not the expected next phase → FAULT with code 10.
  - Otherwise, `step_count`++.
  - When `step_count` reaches the target, or on `abort`, the block enters STOP.
  - A step and `abort` in the same cycle: the step is counted, then the block enters STOP.
- STOP: `dir`=00. When `phase`==0 is sampled, `done` pulses for one cycle and the block returns to IDLE.
  - A nonzero phase change while in STOP (one overshoot step from driver tick alignment) is not counted and is not a fault.
  - An illegal code in STOP → FAULT with code 01.
- Stall watchdog: counts clocks since state entry or the last step event, in RUN and STOP only. Reaching `STALL_CYCLES` → FAULT with code 11.
- FAULT: `dir`=00, `fault`=1, `busy`=0; `step_count` is frozen. `fault_clr` → IDLE and clears `fault_code`. `start` is ignored.
- All counters are W or log2(`STALL_CYCLES`)+1 bits and never wrap; `step_count` saturates at the target.

## Timing
- Reset (`reset_n`=0 at a clk edge) forces: state IDLE, `dir`=00, `busy`=0, `done`=0, `fault`=0, `fault_code`=00, `step_count`=0, `phase_q`=0, watchdog=0.
- Reset mid-move stops the motor: `dir`=00 the cycle after reset is sampled.
- All outputs are registered.
- `start` sampled at edge N → `busy`=1 and `dir` valid after edge N.
- Final step sampled at edge N → `step_count`=target and `dir`=00 after edge N.
- `phase`==0 sampled at edge M → `done`=1 for exactly the cycle after M; `busy`=0 in that same cycle.
- A fault is detected at edge N → `fault`=1 and `dir`=00 after edge N.
- Back-to-back moves: `start` is accepted in the cycle following `done`.

## Test plan
- Reset with `phase`=4 and `start`=1 → all outputs 0. The next `start` with `steps`=3, `reel_out`=1 and driver model phases 1,2,4 → `step_count`=3, `dir` 11→00, then `done` 1 cycle after phase 0.
- Reel in, `steps`=5, from `phase_q`=0 with sequence 8,4,2,1,8 → `step_count`=5, `done`. A single overshoot phase 4 injected in STOP → no fault, count stays 5.
- RUN reel out, phase 2→1 → `fault`=1, `fault_code`=10, `dir`=00. Phase 2→3 → `fault_code`=01. `fault_clr` → IDLE, code 00.
- No phase change for 1024 cycles in RUN → `fault_code`=11. STOP with phase stuck at 8 → `fault_code`=11 after 1024 cycles.
- `steps`=0 with `start` → `done` pulse next cycle, `dir` stays 00, `busy` never high. `abort` at step 2 of 10 → STOP, `step_count`=2, `done`.
- `reset_n` low mid-RUN at step 7 → next cycle `dir`=00, `step_count`=0, state IDLE. `start` during RUN → ignored, target unchanged.
